// File: rtl/acqbuf_writer.sv
// Acquisition capture stage: picks one ADC channel, waits a programmed delay after a
// start strobe, then decimates and writes one full shot of words into the acquisition BRAM.
module acqbuf_writer #(
    parameter int NADC = 4,
    parameter int DW   = 64,
    parameter int AW   = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NADC*DW-1:0]   adc,
    input  logic [15:0]          acqchansel,
    input  logic [31:0]          delayaftertrig,
    input  logic [15:0]          decimator,
    input  logic                 stb_start,
    input  logic                 acqbufreset,
    output logic [AW-1:0]        addr_acqbuf,
    output logic [DW-1:0]        data_acqbuf,
    output logic                 we_acqbuf,
    output logic                 busy,
    output logic                 done
);

    // state   | meaning
    // IDLE    | waiting for a start strobe
    // DELAY   | counting down the post-trigger delay; dcnt==0 is also capture 0
    // CAPTURE | decimated capture; stays one extra cycle after the last capture
    //         | so the final pipelined write goes out before DONE
    // DONE    | buffer full, waiting for a restart
    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_CAPTURE, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [31:0]     dcnt, dcnt_nxt;
    logic [15:0]     ph, ph_nxt;
    logic [AW:0]     wa, wa_nxt;
    logic [15:0]     chansel_q, dec_q;
    logic [DW-1:0]   sel_word;
    logic            fire, load_cfg;
    logic [1:0]      rst_sync;
    logic            rst_int;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_sync <= 2'b11;
        else       rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst_int = rst_sync[1];

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NADC; k++) begin
            if (chansel_q == 16'(k)) sel_word = adc[k*DW +: DW];
        end
    end

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        ph_nxt    = ph;
        wa_nxt    = wa;
        fire      = 1'b0;
        load_cfg  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (stb_start) begin
                    state_nxt = S_DELAY;
                    dcnt_nxt  = delayaftertrig;
                    ph_nxt    = '0;
                    wa_nxt    = '0;
                    load_cfg  = 1'b1;
                end
            end
            S_DELAY: begin
                if (dcnt == 32'd0) begin
                    fire      = 1'b1;
                    wa_nxt    = wa + 1'b1;
                    ph_nxt    = dec_q;
                    state_nxt = S_CAPTURE;
                end else begin
                    dcnt_nxt = dcnt - 32'd1;
                end
            end
            S_CAPTURE: begin
                if (wa[AW]) begin
                    state_nxt = S_DONE;
                end else if (ph == 16'd0) begin
                    fire   = 1'b1;
                    wa_nxt = wa + 1'b1;
                    ph_nxt = dec_q;
                end else begin
                    ph_nxt = ph - 16'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (acqbufreset) begin
            state_nxt = S_IDLE;
            dcnt_nxt  = '0;
            ph_nxt    = '0;
            wa_nxt    = '0;
            load_cfg  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state     <= S_IDLE;
            dcnt      <= '0;
            ph        <= '0;
            wa        <= '0;
            chansel_q <= '0;
            dec_q     <= '0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            ph    <= ph_nxt;
            wa    <= wa_nxt;
            if (load_cfg) begin
                chansel_q <= acqchansel;
                dec_q     <= decimator;
            end
        end
    end

    // A capture coinciding with an abort is dropped rather than written.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            we_acqbuf   <= 1'b0;
            addr_acqbuf <= '0;
            data_acqbuf <= '0;
        end else begin
            we_acqbuf <= fire & ~acqbufreset;
            if (fire & ~acqbufreset) begin
                addr_acqbuf <= wa[AW-1:0];
                data_acqbuf <= sel_word;
            end
        end
    end

    assign busy = (state == S_DELAY) || (state == S_CAPTURE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_acqbuf_writer.sv
// Self-checking bench for acqbuf_writer: randomized ADC data, per-cycle history, and a
// reference model deriving every expected write from the start cycle and shot settings.
module tb_acqbuf_writer;
    localparam int NADC = 4;
    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NW   = 1 << AW;
    localparam int HMAX = 16384;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NADC*DW-1:0]  adc = '0;
    logic [15:0]         acqchansel = '0;
    logic [31:0]         delayaftertrig = '0;
    logic [15:0]         decimator = '0;
    logic                stb_start = 1'b0;
    logic                acqbufreset = 1'b0;
    logic [AW-1:0]       addr_acqbuf;
    logic [DW-1:0]       data_acqbuf;
    logic                we_acqbuf;
    logic                busy;
    logic                done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cnt_mode = 1'b0;
    int done_cyc = -1;
    int busy_fall = -1;
    logic done_d = 1'b0;
    logic busy_d = 1'b0;
    logic [NADC*DW-1:0] hist [HMAX];
    wr_t log_q[$];
    wr_t exp_q[$];

    acqbuf_writer #(.NADC(NADC), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .adc(adc), .acqchansel(acqchansel),
        .delayaftertrig(delayaftertrig), .decimator(decimator), .stb_start(stb_start),
        .acqbufreset(acqbufreset), .addr_acqbuf(addr_acqbuf), .data_acqbuf(data_acqbuf),
        .we_acqbuf(we_acqbuf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Fresh ADC words every cycle; in count mode channel 2 carries the cycle number.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NADC; k++)
            adc[k*DW +: DW] = cnt_mode ? ((k == 2) ? DW'(cyc) : DW'(cyc + k * 100000)) : DW'($urandom);
    end

    always @(negedge clk) begin
        if (cyc < HMAX) hist[cyc] = adc;
        if (we_acqbuf) log_q.push_back({32'(cyc), addr_acqbuf, data_acqbuf});
        if (done && !done_d) done_cyc = cyc;
        if (!busy && busy_d) busy_fall = cyc;
        done_d = done;
        busy_d = busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_shot(input int ch, input int dly, input int dec, output int t);
        log_q.delete();
        done_cyc  = -1;
        busy_fall = -1;
        acqchansel     = 16'(ch);
        delayaftertrig = 32'(dly);
        decimator      = 16'(dec);
        stb_start = 1'b1;
        t = cyc;
        tick();
        stb_start = 1'b0;
        acqchansel     = 16'($urandom);
        delayaftertrig = $urandom;
        decimator      = 16'($urandom);
    endtask

    task automatic pulse_stb();
        stb_start = 1'b1;
        acqchansel     = 16'($urandom);
        delayaftertrig = $urandom_range(0, 3);
        decimator      = 16'($urandom_range(0, 3));
        tick();
        stb_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reference: capture n samples cycle t+1+dly+n*(dec+1) and is written one cycle later.
    function automatic logic [DW-1:0] exp_word(input int c, input int ch);
        logic [NADC*DW-1:0] w;
        if (ch >= NADC || c >= HMAX) return '0;
        w = hist[c];
        return w[ch*DW +: DW];
    endfunction

    function automatic void build_model(input int t, input int ch, input int dly, input int dec, input int nwr);
        exp_q.delete();
        for (int n = 0; n < nwr; n++) begin
            int c;
            c = t + 1 + dly + n * (dec + 1);
            exp_q.push_back({32'(c + 1), AW'(n), exp_word(c, ch)});
        end
    endfunction

    task automatic test_capture(input string name, input int ch, input int dly, input int dec);
        int t;
        int exp_done;
        bit ok;
        start_shot(ch, dly, dec, t);
        wait_done(dly + NW * (dec + 1) + 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout: done=%b after budget, required 1", name, done);
        end
        build_model(t, ch, dly, dec, NW);
        checks++;
        if (log_q.size() != NW) begin
            errors++;
            $display("FAIL %s write count: got %0d, required %0d", name, log_q.size(), NW);
        end
        for (int n = 0; n < NW && n < log_q.size(); n++) begin
            checks++;
            if (log_q[n] !== exp_q[n]) begin
                errors++;
                $display("FAIL %s write %0d: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                         name, n, log_q[n].cyc, log_q[n].addr, log_q[n].data,
                         exp_q[n].cyc, exp_q[n].addr, exp_q[n].data);
            end
        end
        exp_done = t + 1 + dly + (NW - 1) * (dec + 1) + 2;
        checks++;
        if (done_cyc != exp_done) begin
            errors++;
            $display("FAIL %s done rise cycle: got %0d, required %0d", name, done_cyc, exp_done);
        end
        checks++;
        if (busy_fall != exp_done) begin
            errors++;
            $display("FAIL %s busy fall cycle: got %0d, required %0d", name, busy_fall, exp_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({we_acqbuf, busy, done} !== 3'b000 || addr_acqbuf !== '0 || data_acqbuf !== '0) begin
            errors++;
            $display("FAIL reset outputs: got we=%b busy=%b done=%b addr=%0d data=%h, required all 0",
                     we_acqbuf, busy, done, addr_acqbuf, data_acqbuf);
        end
        reset = 1'b0;
        repeat (5) tick();
        checks++;
        if ({we_acqbuf, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset idle: got we=%b busy=%b done=%b, required 000", we_acqbuf, busy, done);
        end
    endtask

    task automatic test_contiguous();
        int t0;
        cnt_mode = 1'b1;
        t0 = cyc;
        test_capture("contiguous", 2, 0, 0);
        checks++;
        if (log_q.size() == 0 || log_q[0].data !== DW'(log_q[0].cyc - 1)) begin
            errors++;
            $display("FAIL contiguous first data: got %0d, required write cycle minus one (%0d)",
                     log_q.size() ? log_q[0].data : 0, log_q.size() ? log_q[0].cyc - 1 : 0);
        end
        cnt_mode = 1'b0;
        checks++;
        if (t0 == cyc) begin
            errors++;
            $display("FAIL contiguous progress: cycle count %0d did not advance", cyc);
        end
    endtask

    task automatic test_abort();
        int t;
        int target;
        start_shot(1, 3, 0, t);
        target = t + 2 + 3 + 4;
        for (int i = 0; i < 50 && cyc < target; i++) tick();
        acqbufreset = 1'b1;
        stb_start = 1'b1;
        tick();
        acqbufreset = 1'b0;
        stb_start = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({we_acqbuf, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL abort next cycle: got we=%b busy=%b done=%b, required 000", we_acqbuf, busy, done);
        end
        repeat (10) tick();
        checks++;
        if (log_q.size() != 5) begin
            errors++;
            $display("FAIL abort write count: got %0d, required 5", log_q.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort stays idle: busy=%b, required 0", busy);
        end
        test_capture("after_abort", 0, 1, 0);
    endtask

    task automatic test_ignore_restart();
        int t;
        int t2;
        bit ok;
        start_shot(3, 4, 1, t);
        tick();
        pulse_stb();
        for (int i = 0; i < 20 && cyc < t + 12; i++) tick();
        pulse_stb();
        wait_done(80, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ignore timeout: done=%b, required 1", done);
        end
        build_model(t, 3, 4, 1, NW);
        checks++;
        if (log_q.size() != NW) begin
            errors++;
            $display("FAIL ignore write count: got %0d, required %0d", log_q.size(), NW);
        end
        for (int n = 0; n < NW && n < log_q.size(); n++) begin
            checks++;
            if (log_q[n] !== exp_q[n]) begin
                errors++;
                $display("FAIL ignore write %0d: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                         n, log_q[n].cyc, log_q[n].addr, log_q[n].data, exp_q[n].cyc, exp_q[n].addr, exp_q[n].data);
            end
        end
        start_shot(2, 0, 0, t2);
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL restart from done: got busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        wait_done(60, ok);
        checks++;
        if (!ok || log_q.size() != NW || log_q[0].addr !== '0) begin
            errors++;
            $display("FAIL restart shot: got done=%b writes=%0d, required done=1 writes=%0d from addr 0",
                     done, log_q.size(), NW);
        end
    endtask

    task automatic test_slow_decim();
        int t;
        logic [DW-1:0] w0;
        start_shot(1, 0, 16'hFFFF, t);
        repeat (200) tick();
        w0 = exp_word(t + 1, 1);
        checks++;
        if (log_q.size() != 1 || log_q[0].data !== w0 || log_q[0].cyc != 32'(t + 2)) begin
            errors++;
            $display("FAIL slow decim writes: got count=%0d, required exactly one write of %h at cycle %0d",
                     log_q.size(), w0, t + 2);
        end
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL slow decim state: got busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        acqbufreset = 1'b1;
        tick();
        acqbufreset = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        int t;
        start_shot(0, 2, 0, t);
        for (int i = 0; i < 20 && cyc < t + 8; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({we_acqbuf, busy, done} !== 3'b000 || addr_acqbuf !== '0 || data_acqbuf !== '0) begin
            errors++;
            $display("FAIL async reset: got we=%b busy=%b done=%b addr=%0d data=%h, required all 0",
                     we_acqbuf, busy, done, addr_acqbuf, data_acqbuf);
        end
        tick();
        tick();
        reset = 1'b0;
        repeat (6) tick();
        checks++;
        if ({we_acqbuf, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL after async reset: got we=%b busy=%b done=%b, required 000", we_acqbuf, busy, done);
        end
        test_capture("after_reset", 3, 2, 2);
    endtask

    initial begin
        test_reset();
        test_contiguous();
        test_capture("decimated", 1, 5, 2);
        test_capture("bad_channel", 7, 0, 0);
        test_abort();
        test_ignore_restart();
        test_slow_decim();
        test_async_reset();
        for (int i = 0; i < 4; i++)
            test_capture("random", $urandom_range(0, 7), $urandom_range(0, 20), $urandom_range(0, 5));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
